// File: rtl/nios2_mult_pkg.sv
// Shared types and default widths for the pipelined multiply unit.
// Op encoding: LO = low word, XSS/XSU/XUU = high word variants.
package nios2_mult_pkg;

    localparam int MUL_DATA_W = 32;
    localparam int MUL_PART_W = 16;

    typedef enum logic [1:0] {
        MUL_OP_LO  = 2'b00,
        MUL_OP_XSS = 2'b01,
        MUL_OP_XSU = 2'b10,
        MUL_OP_XUU = 2'b11
    } mul_op_e;

endpackage

// File: rtl/nios2_mult_if.sv
// Operand/result bundle between the M stage and the multiply unit.
// master: issues in_*, stall, flush; slave: returns out_*, busy.
interface nios2_mult_if
    import nios2_mult_pkg::*;
#(
    parameter int DATA_W = MUL_DATA_W
) ();

    logic              in_valid;
    mul_op_e           in_op;
    logic [DATA_W-1:0] in_src1;
    logic [DATA_W-1:0] in_src2;
    logic              stall;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] out_result;
    logic              busy;

    modport master (
        output in_valid, in_op, in_src1, in_src2,
        output stall, flush,
        input  out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2,
        input  stall, flush,
        output out_valid, out_result, busy
    );

endinterface

// File: rtl/nios2_mult_limb.sv
// Registered unsigned PART_W x PART_W limb multiply (one DSP block).
// Ports: clk, reset_n (async clear), en, a, b -> p (low OUT_W bits).
module nios2_mult_limb
    import nios2_mult_pkg::*;
#(
    parameter int PART_W = MUL_PART_W,
    parameter int OUT_W  = 2 * MUL_PART_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [PART_W-1:0] a,
    input  logic [PART_W-1:0] b,
    output logic [OUT_W-1:0]  p
);

    // Multiplying at OUT_W keeps exactly the bits the caller wants.
    logic [OUT_W-1:0] a_x;
    logic [OUT_W-1:0] b_x;

    assign a_x = OUT_W'(a);
    assign b_x = OUT_W'(b);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p <= '0;
        end else if (en) begin
            p <= a_x * b_x;
        end
    end

endmodule

// File: rtl/nios2_mult_pipe.sv
// Two-stage limb multiplier with stall/flush; result registered.
// Ports: clk, reset_n, mif (slave). Macro NIOS2_MULT_HI_EN: high ops.
module nios2_mult_pipe
    import nios2_mult_pkg::*;
#(
    parameter int DATA_W = MUL_DATA_W,
    parameter int PART_W = MUL_PART_W
) (
    input logic         clk,
    input logic         reset_n,
    nios2_mult_if.slave mif
);

    localparam int NUM_PARTS = DATA_W / PART_W;
    localparam int NPP       = NUM_PARTS * NUM_PARTS;
    localparam int PP_W      = 2 * PART_W;
`ifdef NIOS2_MULT_HI_EN
    localparam int PROD_W    = 2 * DATA_W;
`else
    localparam int PROD_W    = DATA_W;
`endif

    if (DATA_W % PART_W != 0) begin : g_width_chk
        $fatal(1, "DATA_W must be a multiple of PART_W");
    end

    logic adv;
    logic acc;

    assign adv = ~mif.stall;
    assign acc = mif.in_valid & adv;

    logic              s1_valid;
    logic              s2_valid;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_result_r;
    logic [PP_W-1:0]   pp [NPP];
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] s2_prod;
    logic [DATA_W-1:0] sel;

    for (genvar i = 0; i < NUM_PARTS; i++) begin : g_i
        for (genvar j = 0; j < NUM_PARTS; j++) begin : g_j
`ifdef NIOS2_MULT_HI_EN
            localparam int KEEP_W = PP_W;
`else
            // Low-word only: drop limbs and bits above DATA_W.
            localparam int LEFT   = NUM_PARTS - i - j;
            localparam int KEEP_W =
                (LEFT >= 2) ? PP_W : LEFT * PART_W;
`endif
            if (KEEP_W > 0) begin : g_mul
                logic [KEEP_W-1:0] p;

                nios2_mult_limb #(
                    .PART_W (PART_W),
                    .OUT_W  (KEEP_W)
                ) u_limb (
                    .clk     (clk),
                    .reset_n (reset_n),
                    .en      (adv),
                    .a       (mif.in_src1[i*PART_W +: PART_W]),
                    .b       (mif.in_src2[j*PART_W +: PART_W]),
                    .p       (p)
                );

                assign pp[i*NUM_PARTS+j] = PP_W'(p);
            end else begin : g_none
                assign pp[i*NUM_PARTS+j] = '0;
            end
        end
    end

`ifdef NIOS2_MULT_HI_EN
    mul_op_e           s1_op;
    mul_op_e           s2_op;
    logic [DATA_W-1:0] corr1;
    logic [DATA_W-1:0] corr2;
    logic              neg1;
    logic              neg2;

    assign neg1 = mif.in_src1[DATA_W-1] &
                  ((mif.in_op == MUL_OP_XSS) ||
                   (mif.in_op == MUL_OP_XSU));
    assign neg2 = mif.in_src2[DATA_W-1] &
                  (mif.in_op == MUL_OP_XSS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_op <= MUL_OP_LO;
            s2_op <= MUL_OP_LO;
            corr1 <= '0;
            corr2 <= '0;
        end else if (adv) begin
            s1_op <= mif.in_op;
            s2_op <= s1_op;
            corr1 <= neg1 ? mif.in_src2 : '0;
            corr2 <= neg2 ? mif.in_src1 : '0;
        end
    end
`else
    logic unused_op;
    assign unused_op = ^mif.in_op;
`endif

    // Unsigned limb sum, then signed fixups in the high half.
    always_comb begin
        prod = '0;
        for (int i = 0; i < NUM_PARTS; i++) begin
            for (int j = 0; j < NUM_PARTS; j++) begin
                prod = prod +
                    (PROD_W'(pp[i*NUM_PARTS+j]) << ((i + j) * PART_W));
            end
        end
`ifdef NIOS2_MULT_HI_EN
        prod = prod - {corr1, {DATA_W{1'b0}}};
        prod = prod - {corr2, {DATA_W{1'b0}}};
`endif
    end

`ifdef NIOS2_MULT_HI_EN
    assign sel = (s2_op == MUL_OP_LO) ? s2_prod[DATA_W-1:0]
                                      : s2_prod[PROD_W-1:DATA_W];
`else
    assign sel = s2_prod;
`endif

    // flush overrides stall for the valids; a new op still enters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            out_valid_r  <= 1'b0;
            s2_prod      <= '0;
            out_result_r <= '0;
        end else begin
            if (mif.flush || adv) begin
                s1_valid    <= acc;
                s2_valid    <= s1_valid & ~mif.flush;
                out_valid_r <= s2_valid & ~mif.flush;
            end
            if (adv) begin
                s2_prod <= prod;
            end
            if (adv && !mif.flush && s2_valid) begin
                out_result_r <= sel;
            end
        end
    end

    assign mif.out_valid  = out_valid_r;
    assign mif.out_result = out_result_r;
    assign mif.busy       = s1_valid | s2_valid;

endmodule

// File: tb/tb_nios2_mult_pipe.sv
// Scoreboard bench for nios2_mult_pipe: directed + random ops.
// Expected words come from plain 64-bit arithmetic on the operands.
module tb_nios2_mult_pipe;
    import nios2_mult_pkg::*;

`ifdef NIOS2_MULT_HI_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] E_LO = 32'h0000_0001;
    localparam logic [31:0] E_SS = HI_EN ? 32'h0000_0000 : 32'h1;
    localparam logic [31:0] E_SU = HI_EN ? 32'hFFFF_FFFF : 32'h1;
    localparam logic [31:0] E_UU = HI_EN ? 32'hFFFF_FFFE : 32'h1;

    logic clk;
    logic reset_n;

    nios2_mult_if #(.DATA_W(32)) mif ();

    nios2_mult_pipe #(
        .DATA_W (32),
        .PART_W (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mif     (mif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    logic [31:0] exp_q [$];

    bit          last_stall = 1'b0;
    bit          last_flush = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_res   = 32'h0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h",
                     name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input mul_op_e op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] p;
        x = (op == MUL_OP_XSS || op == MUL_OP_XSU)
            ? {{32{a[31]}}, a} : {32'h0, a};
        y = (op == MUL_OP_XSS) ? {{32{b[31]}}, b} : {32'h0, b};
        p = x * y;
        return (HI_EN && op != MUL_OP_LO) ? p[63:32] : p[31:0];
    endfunction

    always @(posedge clk) begin
        last_stall = mif.stall;
        last_flush = mif.flush;
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_valid", 32'(mif.out_valid), 32'h0);
            chk("rst_result", mif.out_result, 32'h0);
            chk("rst_busy", 32'(mif.busy), 32'h0);
            prev_valid = 1'b0;
            prev_res   = 32'h0;
        end else begin
            if (last_stall && !last_flush) begin
                chk("stall_valid", 32'(mif.out_valid),
                    32'(prev_valid));
                chk("stall_result", mif.out_result, prev_res);
            end else if (mif.out_valid) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out actual=%h required=none",
                             mif.out_result);
                end else begin
                    chk("result", mif.out_result, exp_q.pop_front());
                end
            end else begin
                chk("idle_hold", mif.out_result, prev_res);
            end
            prev_valid = mif.out_valid;
            prev_res   = mif.out_result;
        end
    end

    task automatic drive(input bit v, input mul_op_e op,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit st, input bit fl,
                         input logic [31:0] exp);
        mif.in_valid = v;
        mif.in_op    = op;
        mif.in_src1  = a;
        mif.in_src2  = b;
        mif.stall    = st;
        mif.flush    = fl;
        @(posedge clk);
        if (fl) exp_q.delete();
        if (v && !st) exp_q.push_back(exp);
        #1;
        mif.in_valid = 1'b0;
        mif.stall    = 1'b0;
        mif.flush    = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, MUL_OP_LO, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            idle();
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int c0;
        mul_op_e op;
        logic [31:0] a;
        logic [31:0] b;
        bit v, st, fl;

        reset_n      = 1'b1;
        mif.in_valid = 1'b0;
        mif.in_op    = MUL_OP_LO;
        mif.in_src1  = 32'h0;
        mif.in_src2  = 32'h0;
        mif.stall    = 1'b0;
        mif.flush    = 1'b0;
        #2 reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n   = 1'b1;

        // op in flight killed by reset
        drive(1'b1, MUL_OP_LO, 32'h1234, 32'h5678, 1'b0, 1'b0,
              32'h0);
        idle();
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // latency: exactly two edges, busy during both
        drive(1'b1, MUL_OP_LO, 32'h0001_0003, 32'h0002_0005,
              1'b0, 1'b0, 32'h000B_000F);
        @(negedge clk);
        chk("lat_busy1", 32'(mif.busy), 32'h1);
        chk("lat_valid1", 32'(mif.out_valid), 32'h0);
        idle();
        @(negedge clk);
        chk("lat_busy2", 32'(mif.busy), 32'h1);
        chk("lat_valid2", 32'(mif.out_valid), 32'h0);
        idle();
        @(negedge clk);
        chk("lat_valid3", 32'(mif.out_valid), 32'h1);
        chk("lat_busy3", 32'(mif.busy), 32'h0);
        drain();

        // four modes with a 2-cycle stall after the second
        drive(1'b1, MUL_OP_LO, ONES, ONES, 1'b0, 1'b0, E_LO);
        drive(1'b1, MUL_OP_XSS, ONES, ONES, 1'b0, 1'b0, E_SS);
        drive(1'b1, MUL_OP_XSU, ONES, ONES, 1'b1, 1'b0, 32'h0);
        drive(1'b1, MUL_OP_XSU, ONES, ONES, 1'b1, 1'b0, 32'h0);
        drive(1'b1, MUL_OP_XSU, ONES, ONES, 1'b0, 1'b0, E_SU);
        drive(1'b1, MUL_OP_XUU, ONES, ONES, 1'b0, 1'b0, E_UU);
        drain();

        // flush as B moves to stage 2; C enters on the same edge
        drive(1'b1, MUL_OP_LO, 32'd7, 32'd9, 1'b0, 1'b0, 32'd63);
        drive(1'b1, MUL_OP_LO, 32'd5, 32'd5, 1'b0, 1'b0, 32'd25);
        c0 = n_out;
        drive(1'b1, MUL_OP_LO, 32'd11, 32'd13, 1'b0, 1'b1,
              32'd143);
        repeat (4) idle();
        drain();
        chk("flush_once", 32'(n_out - c0), 32'h1);

        // flush + stall: both in-flight ops die, nothing enters
        drive(1'b1, MUL_OP_LO, 32'd3, 32'd3, 1'b0, 1'b0, 32'd9);
        drive(1'b1, MUL_OP_LO, 32'd4, 32'd4, 1'b0, 1'b0, 32'd16);
        c0 = n_out;
        drive(1'b1, MUL_OP_LO, 32'd6, 32'd6, 1'b1, 1'b1, 32'h0);
        @(negedge clk);
        chk("fs_busy", 32'(mif.busy), 32'h0);
        repeat (4) idle();
        chk("fs_none", 32'(n_out - c0), 32'h0);

        // random traffic with sporadic stall and flush
        for (int i = 0; i < 1000; i++) begin
            op = mul_op_e'($urandom_range(0, 3));
            a  = $urandom();
            b  = $urandom();
            if ($urandom_range(0, 7) == 0) a = ONES;
            if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 29) == 0);
            drive(v, op, a, b, st, fl, ref_mul(op, a, b));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
